// File: rtl/f32_mult_arb.sv
// Round-robin arbiter that time-shares one f32 multiplier among N_REQ requesters.
// Latency: handshake T, mul_start T+1, response one cycle after mul_done (or TIMEOUT WAIT cycles).
// Backpressure: one operation in flight; req_ready stays low until the response is accepted.
module f32_mult_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_p,
    output logic                 rsp_underflow,
    output logic                 rsp_overflow,
    output logic                 rsp_timeout,
    output logic                 mul_start,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic                 mul_done,
    input  logic [31:0]          mul_p,
    input  logic                 mul_underflow,
    input  logic                 mul_overflow,
    output logic                 busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gnt_q, gnt_d;
    logic [WW-1:0]  wdog_q, wdog_d;
    logic [31:0]    mul_a_q, mul_a_d;
    logic [31:0]    mul_b_q, mul_b_d;
    logic [31:0]    rsp_p_q, rsp_p_d;
    logic           rsp_uf_q, rsp_uf_d;
    logic           rsp_of_q, rsp_of_d;
    logic           rsp_to_q, rsp_to_d;

    logic           found;
    logic [IW-1:0]  sel;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        wdog_d    = wdog_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        rsp_p_d   = rsp_p_q;
        rsp_uf_d  = rsp_uf_q;
        rsp_of_d  = rsp_of_q;
        rsp_to_d  = rsp_to_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[sel] = 1'b1;
                    mul_a_d        = req_a[32*int'(sel) +: 32];
                    mul_b_d        = req_b[32*int'(sel) +: 32];
                    gnt_d          = sel;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    rsp_p_d  = mul_p;
                    rsp_uf_d = mul_underflow;
                    rsp_of_d = mul_overflow;
                    rsp_to_d = 1'b0;
                    state_d  = RESP;
                end else if (wdog_q == WW'(TIMEOUT-1)) begin
                    rsp_p_d  = 32'h7FC0_0000;
                    rsp_uf_d = 1'b0;
                    rsp_of_d = 1'b0;
                    rsp_to_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == IW'(N_REQ-1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            wdog_q   <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_p_q  <= '0;
            rsp_uf_q <= 1'b0;
            rsp_of_q <= 1'b0;
            rsp_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            wdog_q   <= wdog_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rsp_p_q  <= rsp_p_d;
            rsp_uf_q <= rsp_uf_d;
            rsp_of_q <= rsp_of_d;
            rsp_to_q <= rsp_to_d;
        end
    end

    assign mul_start     = (state_q == ISSUE);
    assign busy          = (state_q != IDLE);
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign rsp_p         = rsp_p_q;
    assign rsp_underflow = rsp_uf_q;
    assign rsp_overflow  = rsp_of_q;
    assign rsp_timeout   = rsp_to_q;

endmodule

// File: tb/tb_f32_mult_arb.sv
// Bench for f32_mult_arb: 4 requesters, TIMEOUT=8, behavioural multiplier with L=4.
module tb_f32_mult_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  rsp_p, mul_a, mul_b, mul_p;
    logic         rsp_underflow, rsp_overflow, rsp_timeout;
    logic         mul_start, mul_done, mul_underflow, mul_overflow, busy;

    f32_mult_arb #(.N_REQ(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .rsp_underflow(rsp_underflow), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .mul_underflow(mul_underflow), .mul_overflow(mul_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: known products looked up by operand pair, done 4 cycles after start.
    function automatic logic [33:0] mock_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {2'b00, 32'h4000_0000};
            64'h40000000_40400000: return {2'b00, 32'h40C0_0000};
            64'h40400000_40400000: return {2'b00, 32'h4110_0000};
            64'h7F000000_7F000000: return {2'b01, 32'h7F80_0000};
            64'h00800000_00800000: return {2'b10, 32'h0000_0000};
            default:               return {2'b00, 32'hDEAD_BEEF};
        endcase
    endfunction

    logic [1:0]  mcnt;
    logic        mdone, stall, inj_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 2'd0; mdone <= 1'b0; mul_p <= '0; mul_underflow <= 1'b0; mul_overflow <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (mul_start && !stall) mcnt <= 2'd3;
            else if (mcnt != 2'd0) begin
                mcnt <= mcnt - 2'd1;
                if (mcnt == 2'd1) begin
                    mdone <= 1'b1;
                    {mul_underflow, mul_overflow, mul_p} <= mock_mul(mul_a, mul_b);
                end
            end
        end
    end
    assign mul_done = mdone | inj_done;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_p"}, rsp_p, 0);
        check({tag, "_flags"}, {29'd0, rsp_underflow, rsp_overflow, rsp_timeout}, 0);
        check({tag, "_mul_start"}, 32'(mul_start), 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One isolated request; expects start at T+1 and rsp_valid at T+6 with L=4.
    task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic uf, input logic of);
        int n;
        @(negedge clk);
        req_valid[idx] = 1'b1;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        #1 check("grant", 32'(req_ready), 32'(1) << idx);
        @(negedge clk);
        req_valid = '0;
        #1 check("start_t1", 32'(mul_start), 1);
        check("mul_a", mul_a, a);
        check("mul_b", mul_b, b);
        check("ready_low_issue", 32'(req_ready), 0);
        @(negedge clk);
        #1 check("start_t2", 32'(mul_start), 0);
        n = 2;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk); #1 n++;
        end
        check("rsp_latency", n, 6);
        check("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
        check("rsp_p", rsp_p, p);
        check("rsp_flags", {29'd0, rsp_underflow, rsp_overflow, rsp_timeout}, {29'd0, uf, of, 1'b0});
        @(negedge clk);
        #1 check("idle_after_rsp", {30'd0, busy, |rsp_valid}, 0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a, b, p;
        logic        uf, of;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int n, g, r, cyc, last, bad;
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
        vecs[1] = '{2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0};
        vecs[2] = '{3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1};
        vecs[3] = '{1, 32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 1'b0};

        rst_n = 1'b0; req_valid = '0; rsp_ready = '1; stall = 1'b0; inj_done = 1'b0;
        req_a = '0; req_b = '0;
        #1 check_zero_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_one(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].uf, vecs[i].of);

        // All requesters continuously valid after a fresh reset: 0,1,2,3,0 every 7 cycles.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req_a = {4{32'h40400000}}; req_b = {4{32'h40400000}};
        g = 0; r = 0; cyc = 0; last = 0; bad = 0;
        while ((g < 5 || r < 5) && cyc < 200) begin
            @(negedge clk); cyc++;
            if (cyc == 1) req_valid = '1;
            if (g == 5) req_valid = '0;
            #1;
            if ($countones(req_ready) > 1) bad++;
            if (req_ready != 0 && g < 5) begin
                check("rr_order", 32'(req_ready), 32'(1) << (g % 4));
                if (g > 0) check("rr_period", cyc - last, 7);
                last = cyc; g++;
            end
            if (rsp_valid != 0) begin
                check("rr_rsp_p", rsp_p, 32'h41100000);
                r++;
            end
        end
        check("rr_grants", g, 5);
        check("rr_rsps", r, 5);
        check("rr_onehot", bad, 0);
        req_valid = '0;
        @(negedge clk);

        // Response backpressure on requester 1 while requester 2 waits.
        rsp_ready = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0110;
        #1 check("bp_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0100;
        n = 0;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk); #1 n++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (rsp_valid != 4'b0010 || rsp_p != 32'h41100000 || req_ready != 0 || !busy) bad++;
        end
        check("bp_hold", bad, 0);
        @(negedge clk);
        rsp_ready = 4'b0011;
        #1 check("bp_release_rsp", 32'(rsp_valid), 32'b0010);
        @(negedge clk);
        #1 check("bp_grant2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0; rsp_ready = '1;
        n = 0;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk); #1 n++;
        end
        check("bp_rsp2", 32'(rsp_valid), 32'b0100);
        @(negedge clk);

        // Watchdog: multiplier never answers; response TIMEOUT cycles after WAIT entry.
        stall = 1'b1;
        @(negedge clk);
        req_valid = 4'b1000;
        #1 check("to_grant", 32'(req_ready), 32'b1000);
        n = 0;
        @(negedge clk); req_valid = '0; #1 n = 1;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk); #1 n++;
        end
        check("to_latency", n, 10);
        check("to_rsp_valid", 32'(rsp_valid), 32'b1000);
        check("to_rsp_p", rsp_p, 32'h7FC00000);
        check("to_flags", {29'd0, rsp_underflow, rsp_overflow, rsp_timeout}, 32'b001);
        @(negedge clk);
        inj_done = 1'b1;
        #1 check("to_idle", 32'(busy), 0);
        @(negedge clk);
        inj_done = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (rsp_valid != 0 || busy) bad++;
        end
        check("late_done_ignored", bad, 0);
        stall = 1'b0;

        // Move ptr away from 0, then reset in the middle of WAIT.
        run_one(1, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'h40000000; req_b[64 +: 32] = 32'h40400000;
        #1 check("mr_grant", 32'(req_ready), 32'b0100);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1 check("mr_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (rsp_valid != 0 || busy) bad++;
        end
        check("mr_no_stale", bad, 0);
        @(negedge clk);
        req_valid = '1;
        #1 check("mr_ptr_zero", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid == 0 && n < 40) begin
            @(negedge clk); #1 n++;
        end
        check("mr_rsp", 32'(rsp_valid), 32'b0001);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
